// File: rtl/frame_checker_if.sv
// FIFO-side bundle of the frame checker: input FIFO read port
// and output FIFO write port.
interface frame_checker_if #(
    parameter int FIFO_WIDTH = 36
);
    logic                  in_empty;
    logic                  in_rd_en;
    logic [FIFO_WIDTH-1:0] in_data;
    logic                  out_full;
    logic                  out_wr_en;
    logic [FIFO_WIDTH-1:0] out_data;

    modport master (
        output in_empty,
        output in_data,
        output out_full,
        input  in_rd_en,
        input  out_wr_en,
        input  out_data
    );

    modport slave (
        input  in_empty,
        input  in_data,
        input  out_full,
        output in_rd_en,
        output out_wr_en,
        output out_data
    );
endinterface

// File: rtl/frame_checker.sv
// Frame alignment checker and tagger between packer FIFO and readout FIFO.
// Define FRAME_TRAILER_EN to append a trailer word after every frame.
module frame_checker #(
    parameter int         FIFO_WIDTH   = 36,
    parameter int         FRAME_WORDS  = 12,
    parameter logic [7:0] FRAME_HEADER = 8'hBC,
    parameter int         CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    frame_checker_if.slave       fifo,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output logic [CNT_WIDTH-1:0] err_cnt,
    output logic                 busy
);

    localparam logic [3:0] TAG_HDR  = 4'h1;
    localparam logic [3:0] TAG_BODY = 4'h0;

`ifdef FRAME_TRAILER_EN
    localparam logic [3:0] TAG_TRL = 4'hE;

    typedef enum logic [1:0] {
        HUNT,
        BODY,
        TRAILER
    } state_t;
`else
    typedef enum logic [1:0] {
        HUNT,
        BODY
    } state_t;
`endif

    state_t                state;
    logic                  rd_pend;
    logic [5:0]            word_cnt;
    logic                  err_run;
    logic                  hold_valid;
    logic [FIFO_WIDTH-1:0] hold_data;
    logic                  out_valid;
    logic [FIFO_WIDTH-1:0] out_q;

    logic                  rd_ok;
    logic [6:0]            issued;
    logic                  hdr_hit;
    logic                  last_word;
    logic                  out_free;
    logic                  ret_push;
    logic [3:0]            ret_tag;
    logic [FIFO_WIDTH-1:0] ret_data;
    logic                  unused_tag;

    // Words already counted plus the one in flight bound the frame.
    assign issued    = {1'b0, word_cnt} + {6'd0, rd_pend};
    assign hdr_hit   = fifo.in_data[31:24] == FRAME_HEADER;
    assign last_word = (word_cnt + 6'd1) == 6'(FRAME_WORDS);
    assign out_free  = !out_valid || !fifo.out_full;
    assign ret_data  = FIFO_WIDTH'({ret_tag, fifo.in_data[31:0]});
    assign unused_tag = ^fifo.in_data[FIFO_WIDTH-1:32];

    always_comb begin
        rd_ok = 1'b0;
        unique case (state)
            HUNT:    rd_ok = enable;
            BODY:    rd_ok = issued < 7'(FRAME_WORDS);
            default: rd_ok = 1'b0;
        endcase
    end

    always_comb begin
        ret_push = 1'b0;
        ret_tag  = TAG_BODY;
        if (rd_pend) begin
            unique case (state)
                HUNT: begin
                    ret_push = hdr_hit;
                    ret_tag  = TAG_HDR;
                end
                BODY:    ret_push = 1'b1;
                default: ret_push = 1'b0;
            endcase
        end
    end

`ifdef FRAME_TRAILER_EN
    logic                  trl_go;
    logic [FIFO_WIDTH-1:0] trl_data;

    assign trl_go   = (state == TRAILER) && !hold_valid && out_free;
    assign trl_data = FIFO_WIDTH'({TAG_TRL, 16'(frame_cnt),
                                   8'h00, 8'(FRAME_WORDS)});
`endif

    assign fifo.in_rd_en  = !rst && rd_ok && !fifo.in_empty
                          && !fifo.out_full && !hold_valid;
    assign fifo.out_wr_en = !rst && out_valid && !fifo.out_full;
    assign fifo.out_data  = out_q;
    assign busy           = state != HUNT;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            rd_pend    <= 1'b0;
            word_cnt   <= '0;
            err_run    <= 1'b0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            out_valid  <= 1'b0;
            out_q      <= '0;
            frame_cnt  <= '0;
            err_cnt    <= '0;
        end else begin
            rd_pend <= fifo.in_rd_en;

            // Output register drains; hold entry is always older than
            // a fresh return, so it goes first.
            if (out_free) begin
                out_valid <= 1'b0;
            end
            if (hold_valid && out_free) begin
                out_q      <= hold_data;
                out_valid  <= 1'b1;
                hold_valid <= 1'b0;
            end else if (ret_push && out_free) begin
                out_q     <= ret_data;
                out_valid <= 1'b1;
            end else if (ret_push) begin
                hold_data  <= ret_data;
                hold_valid <= 1'b1;
`ifdef FRAME_TRAILER_EN
            end else if (trl_go) begin
                out_q     <= trl_data;
                out_valid <= 1'b1;
`endif
            end

            if (rd_pend) begin
                unique case (state)
                    HUNT: begin
                        if (hdr_hit) begin
                            state    <= BODY;
                            word_cnt <= 6'd1;
                            err_run  <= 1'b0;
                        end else if (!err_run) begin
                            err_run <= 1'b1;
                            if (err_cnt != '1) begin
                                err_cnt <= err_cnt + CNT_WIDTH'(1);
                            end
                        end
                    end
                    BODY: begin
                        word_cnt <= word_cnt + 6'd1;
                        if (last_word) begin
                            frame_cnt <= frame_cnt + CNT_WIDTH'(1);
`ifdef FRAME_TRAILER_EN
                            state <= TRAILER;
`else
                            state <= HUNT;
`endif
                        end
                    end
                    default: ;
                endcase
            end

`ifdef FRAME_TRAILER_EN
            if (trl_go) begin
                state <= HUNT;
            end
`endif
        end
    end

endmodule

// File: tb/tb_frame_checker.sv
// Scoreboard bench for frame_checker: random traffic against a
// list-level model of frame hunting, tagging and counters.
module tb_frame_checker;

    localparam int FW = 12;

    typedef logic [31:0] wq_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;
    logic        busy;
    logic [3:0]  w_frame_cnt;
    logic [3:0]  w_err_cnt;
    logic        w_busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    frame_checker_if #(.FIFO_WIDTH(36)) ifc ();
    frame_checker_if #(.FIFO_WIDTH(36)) w_if ();

    frame_checker #(
        .FIFO_WIDTH(36),
        .FRAME_WORDS(FW),
        .FRAME_HEADER(8'hBC),
        .CNT_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .fifo(ifc.slave),
        .frame_cnt(frame_cnt),
        .err_cnt(err_cnt),
        .busy(busy)
    );

    // Narrow counters and 2-word frames reach wrap/saturation quickly.
    frame_checker #(
        .FIFO_WIDTH(36),
        .FRAME_WORDS(2),
        .FRAME_HEADER(8'hBC),
        .CNT_WIDTH(4)
    ) dut_w (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .fifo(w_if.slave),
        .frame_cnt(w_frame_cnt),
        .err_cnt(w_err_cnt),
        .busy(w_busy)
    );

    logic [35:0] in_q[$];
    logic [35:0] w_q[$];
    logic [35:0] exp_q[$];
    int          rd_count = 0;
    int          n_out = 0;
    int          wr_full_viol = 0;
    bit          bp_on = 1'b0;
    int          bp_cnt = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        ifc.in_empty  = 1'b1;
        ifc.in_data   = '0;
        ifc.out_full  = 1'b0;
        w_if.in_empty = 1'b1;
        w_if.in_data  = '0;
        w_if.out_full = 1'b0;
    end

    always @(posedge clk) begin : in_fifo
        logic pop;
        pop = ifc.in_rd_en;
        #1;
        if (pop && in_q.size() > 0) begin
            rd_count++;
            ifc.in_data = in_q.pop_front();
        end
        ifc.in_empty = in_q.size() == 0;
    end

    always @(posedge clk) begin : w_fifo
        logic pop;
        pop = w_if.in_rd_en;
        #1;
        if (pop && w_q.size() > 0) begin
            w_if.in_data = w_q.pop_front();
        end
        w_if.in_empty = w_q.size() == 0;
    end

    always @(posedge clk) begin : full_drv
        #1;
        if (bp_on) begin
            bp_cnt++;
            if (bp_cnt % 3 == 0) begin
                ifc.out_full = !ifc.out_full;
            end
        end else begin
            ifc.out_full = 1'b0;
        end
    end

    always @(negedge clk) begin : monitor
        if (ifc.out_wr_en && ifc.out_full) begin
            wr_full_viol++;
        end
        if (ifc.out_wr_en) begin
            n_out++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL out_unexpected actual=%0h required=none",
                         ifc.out_data);
            end else begin
                check("out_word", ifc.out_data, exp_q.pop_front());
            end
        end
    end

    // Reference: scan the word list, hunt for headers, emit whole frames.
    int m_frames = 0;
    int m_errs = 0;
    bit m_run = 1'b0;

    function automatic void model(input wq_t w);
        int i = 0;
        while (i < w.size()) begin
            if (w[i][31:24] == 8'hBC) begin
                m_run = 1'b0;
                for (int k = 0; k < FW && i + k < w.size(); k++) begin
                    exp_q.push_back({(k == 0) ? 4'h1 : 4'h0, w[i+k]});
                end
                if (i + FW <= w.size()) begin
                    m_frames = (m_frames + 1) % 65536;
`ifdef FRAME_TRAILER_EN
                    exp_q.push_back({4'hE, 16'(m_frames), 8'h00, 8'(FW)});
`endif
                end
                i += FW;
            end else begin
                if (!m_run && m_errs < 65535) begin
                    m_errs++;
                end
                m_run = 1'b1;
                i++;
            end
        end
    endfunction

    function automatic wq_t mk_frame(input logic [31:0] hdr);
        wq_t f;
        f.push_back(hdr);
        for (int k = 1; k < FW; k++) begin
            f.push_back($urandom);
        end
        return f;
    endfunction

    function automatic logic [31:0] junk();
        logic [31:0] v;
        v = $urandom;
        if (v[31:24] == 8'hBC) begin
            v[31:24] = 8'h3C;
        end
        return v;
    endfunction

    task automatic feed(input wq_t w, input int max_gap);
        model(w);
        foreach (w[i]) begin
            in_q.push_back({4'($urandom), w[i]});
            repeat ($urandom_range(max_gap, 0)) tick();
        end
    endtask

    task automatic wait_drain(input string name, input bit need_idle,
                              output int n);
        n = 0;
        while ((exp_q.size() != 0 || in_q.size() != 0
                || (need_idle && busy)) && n < 3000) begin
            tick();
            n++;
        end
        check({name, "_done"}, n < 3000, 1);
        repeat (3) tick();
    endtask

    task automatic check_counts(input string name);
        check({name, "_frame_cnt"}, frame_cnt, 16'(m_frames));
        check({name, "_err_cnt"}, err_cnt, 16'(m_errs));
    endtask

    task automatic check_reset(input string name);
        check({name, "_in_rd_en"}, ifc.in_rd_en, 0);
        check({name, "_out_wr_en"}, ifc.out_wr_en, 0);
        check({name, "_out_data"}, ifc.out_data, 0);
        check({name, "_frame_cnt"}, frame_cnt, 0);
        check({name, "_err_cnt"}, err_cnt, 0);
        check({name, "_busy"}, busy, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        wq_t w;
        int  n;
        int  t;
        int  snap;
        int  base;
        int  rem;
        bit  w_to;

        rst    = 1'b1;
        enable = 1'b1;
        repeat (3) tick();
        check_reset("reset");
        rst = 1'b0;
        tick();

        // Clean stream, back to back, headers 0xBC000001..3
        w.delete();
        for (int f = 0; f < 3; f++) begin
            w = {w, mk_frame(32'hBC00_0000 + 32'(f + 1))};
        end
        feed(w, 0);
        wait_drain("clean", 1'b1, n);
        check("clean_cycles_le50", n <= 50, 1);
        check_counts("clean");

        // Misalignment: garbage run ahead of a frame
        w.delete();
        repeat (5) w.push_back(32'h1111_1111);
        w = {w, mk_frame(32'hBC00_0004)};
        feed(w, 0);
        wait_drain("misalign", 1'b1, n);
        check_counts("misalign");

        // Random garbage runs, frames and input gaps
        for (int r = 0; r < 4; r++) begin
            w.delete();
            repeat ($urandom_range(3, 0)) w.push_back(junk());
            w = {w, mk_frame({8'hBC, 24'($urandom)})};
            feed(w, 2);
        end
        wait_drain("random", 1'b1, n);
        check_counts("random");

        // Backpressure: out_full toggles every 3 cycles
        bp_on = 1'b1;
        w = mk_frame(32'hBC00_0010);
        w = {w, mk_frame(32'hBC00_0011)};
        feed(w, 0);
        wait_drain("backpressure", 1'b1, n);
        bp_on = 1'b0;
        tick();
        check_counts("backpressure");

        // Enable dropped at word 5 of frame A; frame B must wait
        feed(mk_frame(32'hBC00_0020), 0);
        base = exp_q.size();
        feed(mk_frame(32'hBC00_0021), 0);
        rem  = exp_q.size() - base;
        base = n_out;
        t = 0;
        while (n_out < base + 5 && t < 500) begin
            tick();
            t++;
        end
        enable = 1'b0;
        t = 0;
        while (exp_q.size() > rem && t < 500) begin
            tick();
            t++;
        end
        check("en_frame_a_done", t < 500, 1);
        repeat (3) tick();
        snap = rd_count;
        repeat (20) tick();
        check("en_low_no_reads", rd_count - snap, 0);
        check("en_low_pending", exp_q.size(), rem);
        check("en_low_busy", busy, 0);
        enable = 1'b1;
        snap = rd_count;
        repeat (2) tick();
        check("en_resume", rd_count != snap, 1);
        wait_drain("enable", 1'b1, n);
        check_counts("enable");

        // Reset after 7 words of a frame
        w = mk_frame(32'hBC00_0030);
        w = w[0:6];
        feed(w, 0);
        wait_drain("partial", 1'b0, n);
        check("partial_busy", busy, 1);
        rst = 1'b1;
        exp_q.delete();
        m_frames = 0;
        m_errs   = 0;
        m_run    = 1'b0;
        feed(mk_frame(32'hBC00_0031), 0);
        tick();
        check_reset("midreset");
        rst = 1'b0;
        wait_drain("after_reset", 1'b1, n);
        check_counts("after_reset");

        // Narrow counters: 16 x (error run + frame)
        w_to = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            w_q.push_back(36'h0_2222_2222);
            w_q.push_back({4'h0, 8'hBC, 24'(k)});
            w_q.push_back({4'h0, 32'($urandom)});
            t = 0;
            tick();
            while ((w_q.size() != 0 || w_busy) && t < 200) begin
                tick();
                t++;
            end
            if (t >= 200) begin
                w_to = 1'b1;
            end
            repeat (3) tick();
            if (k == 15) begin
                check("w_frame_cnt_15", w_frame_cnt, 4'd15);
                check("w_err_cnt_15", w_err_cnt, 4'd15);
            end
            if (k == 16) begin
                check("w_frame_cnt_wrap", w_frame_cnt, 4'd0);
                check("w_err_cnt_sat", w_err_cnt, 4'd15);
            end
        end
        check("w_timeout", w_to, 0);

        check("wr_while_full", wr_full_viol, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
